shared_compute_engine: RTL and testbench

Parametrised, multi-requester vector compute engine: successor to the fixed 4-unit shared compute block in the accelerator datapath. It arbitrates round-robin among `N_REQ` requesting units, captures one command's operands, and processes `LANES` vector elements per cycle. Supported operations are element add, ternary matrix-vector multiply, sign activation and ReLU. The result is held on a valid/ready output until the owner accepts it.

---
 rtl/shared_compute_engine_pkg.sv | 40 ++++
 rtl/shared_compute_engine_rr_arbiter.sv | 36 +++
 rtl/shared_compute_engine.sv | 210 +++++++++++++++++++++
 tb/tb_shared_compute_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_compute_engine_pkg.sv
// Shared types and helpers for the multi-requester vector compute engine.
// Holds the command encoding, ternary matrix entry, FSM states and saturation helper.
package accel_pkg;

  typedef enum logic [1:0] {
    COMP_ADD  = 2'd0,
    COMP_MUL  = 2'd1,
    COMP_TANH = 2'd2,
    COMP_RELU = 2'd3
  } comp_type_e;

  typedef struct packed {
    logic en;
    logic neg;
  } ternary_t;

  typedef enum logic [1:0] {
    SCE_IDLE    = 2'd0,
    SCE_LOAD    = 2'd1,
    SCE_COMPUTE = 2'd2,
    SCE_RESULT  = 2'd3
  } sce_state_e;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      sat_trunc = max_v;
    end else if (value < min_v) begin
      sat_trunc = min_v;
    end else begin
      sat_trunc = value;
    end
  endfunction

endpackage

// File: rtl/shared_compute_engine_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
// Produces a one-hot select and its encoded index.
module rr_arbiter
  import accel_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic [N_REQ-1:0]         sel,
  output logic [$clog2(N_REQ)-1:0] sel_id
);

  localparam int ID_W = $clog2(N_REQ);

  // Scan from last_owner+1 around the ring; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    sel    = '0;
    sel_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_owner) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        sel[idx] = 1'b1;
        sel_id   = ID_W'(idx);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/shared_compute_engine.sv
// Multi-requester vector engine: round-robin grant, operand capture, LANES elements
// per cycle of ADD / ternary MUL / sign / ReLU, result held on a valid/ready port.
module shared_compute_engine
  import accel_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int VEC_DEPTH = 16,
  parameter int ELEM_W    = 16,
  parameter int LANES     = 1,
  parameter int SAT_EN    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ-1:0][1:0]                 req_op,
  output logic [N_REQ-1:0]                      gnt,
  input  logic [VEC_DEPTH-1:0][ELEM_W-1:0]      op_a,
  input  logic [VEC_DEPTH-1:0][ELEM_W-1:0]      op_b,
  input  logic [VEC_DEPTH-1:0][VEC_DEPTH-1:0][1:0] op_mat,
  output logic                                  busy,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [$clog2(N_REQ)-1:0]              res_id,
  output logic [VEC_DEPTH-1:0][ELEM_W-1:0]      res_data
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(VEC_DEPTH);
  localparam int ACC_W = ELEM_W + $clog2(VEC_DEPTH) + 1;

  sce_state_e                         r_state;
  sce_state_e                         w_next_state;
  logic [ID_W-1:0]                    r_owner;
  logic [ID_W-1:0]                    r_last_owner;
  logic [CNT_W-1:0]                   r_elem_cnt;
  logic [N_REQ-1:0]                   r_gnt;
  logic                               r_busy;
  logic                               r_res_valid;
  logic [ID_W-1:0]                    r_res_id;
  logic [VEC_DEPTH-1:0][ELEM_W-1:0]   r_a;
  logic [VEC_DEPTH-1:0][ELEM_W-1:0]   r_b;
  ternary_t [VEC_DEPTH-1:0][VEC_DEPTH-1:0] r_mat;
  comp_type_e                         r_op;
  logic [VEC_DEPTH-1:0][ELEM_W-1:0]   r_res;
  logic [N_REQ-1:0]                   w_sel;
  logic [ID_W-1:0]                    w_sel_id;
  logic                               w_last_group;
  logic                               w_take;
  logic [LANES-1:0][CNT_W-1:0]        w_idx;
  logic [LANES-1:0][ELEM_W-1:0]       w_lane_res;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_owner (r_last_owner),
    .sel        (w_sel),
    .sel_id     (w_sel_id)
  );

  assign w_take       = (r_state == SCE_IDLE) && (|req_valid);
  assign w_last_group = (r_elem_cnt == CNT_W'(VEC_DEPTH - LANES));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SCE_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SCE_IDLE: begin
        if (|req_valid) w_next_state = SCE_LOAD;
        else            w_next_state = SCE_IDLE;
      end
      SCE_LOAD: w_next_state = SCE_COMPUTE;
      SCE_COMPUTE: begin
        if (w_last_group) w_next_state = SCE_RESULT;
        else              w_next_state = SCE_COMPUTE;
      end
      SCE_RESULT: begin
        if (r_res_valid && res_ready) w_next_state = SCE_IDLE;
        else                          w_next_state = SCE_RESULT;
      end
      default: w_next_state = SCE_IDLE;
    endcase
  end

  // Grant, ownership, element counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= '0;
      r_last_owner <= ID_W'(N_REQ - 1);
      r_elem_cnt   <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
    end else begin
      r_busy      <= (w_next_state != SCE_IDLE);
      r_res_valid <= (w_next_state == SCE_RESULT);
      r_gnt       <= w_take ? w_sel : '0;
      if (w_take) begin
        r_owner <= w_sel_id;
      end
      if (r_state == SCE_LOAD) begin
        r_elem_cnt   <= '0;
        r_last_owner <= r_owner;
        r_res_id     <= r_owner;
      end else if (r_state == SCE_COMPUTE) begin
        r_elem_cnt <= r_elem_cnt + CNT_W'(LANES);
      end
    end
  end

  // Operand capture; the buses are never read after LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_mat <= '0;
      r_op  <= COMP_ADD;
    end else if (r_state == SCE_LOAD) begin
      r_a   <= op_a;
      r_b   <= op_b;
      r_mat <= op_mat;
      r_op  <= comp_type_e'(req_op[r_owner]);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [ELEM_W-1:0] w_a_i;
    logic signed [ELEM_W-1:0] w_b_i;
    logic signed [ELEM_W:0]   w_add;
    logic signed [63:0]       w_add_wide;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [63:0]       w_acc_wide;
    logic [ELEM_W-1:0]        w_res;

    assign w_idx[l]   = r_elem_cnt + CNT_W'(l);
    assign w_a_i      = r_a[w_idx[l]];
    assign w_b_i      = r_b[w_idx[l]];
    assign w_add      = {w_a_i[ELEM_W-1], w_a_i} + {w_b_i[ELEM_W-1], w_b_i};
    assign w_add_wide = {{(64-ELEM_W-1){w_add[ELEM_W]}}, w_add};
    assign w_acc_wide = {{(64-ACC_W){w_acc[ACC_W-1]}}, w_acc};

    // Ternary row dot product: add, subtract or skip each a[j].
    always_comb begin
      w_acc = '0;
      for (int j = 0; j < VEC_DEPTH; j++) begin
        if (r_mat[w_idx[l]][j].en) begin
          if (r_mat[w_idx[l]][j].neg) begin
            w_acc = w_acc - {{(ACC_W-ELEM_W){r_a[j][ELEM_W-1]}}, r_a[j]};
          end else begin
            w_acc = w_acc + {{(ACC_W-ELEM_W){r_a[j][ELEM_W-1]}}, r_a[j]};
          end
        end else begin
          w_acc = w_acc;
        end
      end
    end

    // Per-lane operation select with saturate-or-wrap.
    always_comb begin
      w_res = '0;
      case (r_op)
        COMP_ADD: w_res = (SAT_EN != 0) ? ELEM_W'(sat_trunc(w_add_wide, ELEM_W))
                                        : w_add[ELEM_W-1:0];
        COMP_MUL: w_res = (SAT_EN != 0) ? ELEM_W'(sat_trunc(w_acc_wide, ELEM_W))
                                        : w_acc[ELEM_W-1:0];
        COMP_TANH: begin
          if (w_a_i[ELEM_W-1]) begin
            w_res = {1'b1, {(ELEM_W-1){1'b0}}};
          end else if (w_a_i == '0) begin
            w_res = '0;
          end else begin
            w_res = {1'b0, {(ELEM_W-1){1'b1}}};
          end
        end
        COMP_RELU: w_res = w_a_i[ELEM_W-1] ? '0 : w_a_i;
        default:   w_res = '0;
      endcase
    end

    assign w_lane_res[l] = w_res;
  end

  // Result vector; written only while computing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
    end else if (r_state == SCE_COMPUTE) begin
      for (int l = 0; l < LANES; l++) begin
        r_res[w_idx[l]] <= w_lane_res[l];
      end
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res;

endmodule

// File: tb/tb_shared_compute_engine.sv
// Bench for shared_compute_engine: two instances (LANES=1/saturate, LANES=4/wrap)
// driven by directed and random commands, checked against an arithmetic model.
module tb_shared_compute_engine;

  localparam int NR  = 4;
  localparam int VD  = 16;
  localparam int EW  = 16;
  localparam int OPW = 2 * NR;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]            req_valid [2];
  logic [NR-1:0][1:0]       req_op    [2];
  logic                     res_ready [2];
  logic [NR-1:0]            gnt       [2];
  logic                     busy      [2];
  logic                     res_valid [2];
  logic [1:0]               res_id    [2];
  logic [VD-1:0][EW-1:0]    res_data  [2];
  logic [VD-1:0][EW-1:0]    op_a, op_b;
  logic [VD-1:0][VD-1:0][1:0] op_mat;

  int n_checks = 0;
  int n_errors = 0;
  int last_owner [2];

  shared_compute_engine #(.N_REQ(NR), .VEC_DEPTH(VD), .ELEM_W(EW), .LANES(1), .SAT_EN(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_op(req_op[0]), .gnt(gnt[0]),
    .op_a(op_a), .op_b(op_b), .op_mat(op_mat), .busy(busy[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .res_id(res_id[0]), .res_data(res_data[0]));

  shared_compute_engine #(.N_REQ(NR), .VEC_DEPTH(VD), .ELEM_W(EW), .LANES(4), .SAT_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_op(req_op[1]), .gnt(gnt[1]),
    .op_a(op_a), .op_b(op_b), .op_mat(op_mat), .busy(busy[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .res_id(res_id[1]), .res_data(res_data[1]));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference: each element from the arithmetic definition of the operation.
  function automatic logic [VD-1:0][EW-1:0] ref_vec(input int op, input bit sat,
      input logic [VD-1:0][EW-1:0] a, input logic [VD-1:0][EW-1:0] b,
      input logic [VD-1:0][VD-1:0][1:0] m);
    logic [VD-1:0][EW-1:0] r;
    longint v, ai, bi, aj, maxv, minv;
    maxv = (longint'(1) <<< (EW - 1)) - 1;
    minv = -maxv - 1;
    for (int i = 0; i < VD; i++) begin
      ai = longint'($signed(a[i]));
      bi = longint'($signed(b[i]));
      case (op)
        0: v = ai + bi;
        1: begin
          v = 0;
          for (int j = 0; j < VD; j++) begin
            aj = longint'($signed(a[j]));
            if (m[i][j][1]) v = m[i][j][0] ? v - aj : v + aj;
          end
        end
        2: v = (ai < 0) ? minv : ((ai == 0) ? 0 : maxv);
        default: v = (ai < 0) ? 0 : ai;
      endcase
      if (sat && v > maxv) v = maxv;
      if (sat && v < minv) v = minv;
      r[i] = v[EW-1:0];
    end
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic rand_bus();
    for (int i = 0; i < VD; i++) begin
      op_a[i] = EW'($urandom);
      op_b[i] = EW'($urandom);
      for (int j = 0; j < VD; j++) op_mat[i][j] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", gnt[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_valid", res_valid[d], 0);
      chk("rst_id", res_id[d], 0);
      chk("rst_data", res_data[d], 0);
    end
  endtask

  // One command: request, grant, latency, result, optional backpressure, accept.
  task automatic txn(input int d, input logic [NR-1:0] mask, input logic [NR-1:0][1:0] ops,
                     input int stall, input bit keep, output int unit);
    int exp_u, cyc;
    logic [VD-1:0][EW-1:0] exp_res, held;
    exp_u   = rr_pick(last_owner[d], mask);
    exp_res = ref_vec(int'(ops[exp_u]), (d == 0), op_a, op_b, op_mat);
    req_op[d]    = ops;
    req_valid[d] = mask;
    @(posedge clk);
    @(negedge clk);
    chk("gnt", gnt[d], 4'b0001 << exp_u);
    chk("busy_load", busy[d], 1);
    unit = -1;
    for (int u = 0; u < NR; u++) if (gnt[d][u]) unit = u;
    if (!keep) req_valid[d][exp_u] = 1'b0;
    @(negedge clk);
    cyc = 2;
    rand_bus();
    while (res_valid[d] !== 1'b1 && cyc < 64) begin
      chk("gnt_quiet", gnt[d], 0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 2 + VD / lanes_of(d));
    chk("res_id", res_id[d], exp_u);
    chk("res_data", res_data[d], exp_res);
    held = res_data[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("bp_valid", res_valid[d], 1);
      chk("bp_id", res_id[d], exp_u);
      chk("bp_data", res_data[d], held);
      chk("bp_gnt", gnt[d], 0);
    end
    res_ready[d] = 1'b1;
    @(negedge clk);
    res_ready[d] = 1'b0;
    chk("idle_valid", res_valid[d], 0);
    chk("idle_busy", busy[d], 0);
    if (!keep) req_valid[d] = '0;
    last_owner[d] = exp_u;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VD-1:0][EW-1:0] sa, sb;
    logic [VD-1:0][VD-1:0][1:0] sm;
    logic [NR-1:0][1:0] ops;
    int u;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_op[d] = '0; res_ready[d] = 1'b0; last_owner[d] = NR - 1;
    end
    op_a = '0; op_b = '0; op_mat = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    // ADD: saturate on instance 0, wrap on instance 1.
    rand_bus();
    op_a[0] = 16'h7FF0; op_b[0] = 16'h0020;
    sa = op_a; sb = op_b; sm = op_mat;
    txn(0, 4'b0001, '0, 0, 1'b0, u);
    chk("add_sat_r0", res_data[0][0], 16'h7FFF);
    op_a = sa; op_b = sb; op_mat = sm;
    txn(1, 4'b0001, '0, 0, 1'b0, u);
    chk("add_wrap_r0", res_data[1][0], 16'h8010);

    // Ternary MUL.
    rand_bus();
    op_mat = '0;
    for (int i = 0; i < VD; i++) op_a[i] = EW'(i + 1);
    op_mat[0][0] = 2'b10; op_mat[0][1] = 2'b11;
    for (int j = 0; j < VD; j++) op_mat[1][j] = 2'b10;
    txn(0, 4'b0010, 8'h55, 0, 1'b0, u);
    chk("mul_r0", res_data[0][0], 16'hFFFF);
    chk("mul_r1", res_data[0][1], 16'd136);
    chk("mul_rest", res_data[0][VD-1:2], 0);

    // Sign and ReLU on the same a vector.
    rand_bus();
    op_a[0] = 16'hFFFB; op_a[1] = 16'h0000; op_a[2] = 16'h0007;
    sa = op_a;
    txn(0, 4'b0100, 8'hAA, 0, 1'b0, u);
    chk("tanh_r0", res_data[0][0], 16'h8000);
    chk("tanh_r1", res_data[0][1], 16'h0000);
    chk("tanh_r2", res_data[0][2], 16'h7FFF);
    op_a = sa;
    txn(0, 4'b1000, 8'hFF, 0, 1'b0, u);
    chk("relu_r0", res_data[0][0], 16'h0000);
    chk("relu_r1", res_data[0][1], 16'h0000);
    chk("relu_r2", res_data[0][2], 16'h0007);

    // Round-robin with all four requests held.
    for (int k = 0; k < 5; k++) begin
      rand_bus();
      ops = OPW'($urandom);
      txn(0, 4'b1111, ops, 0, 1'b1, u);
      chk("rr_order", u, k % NR);
    end
    req_valid[0] = '0;
    @(negedge clk);

    // Backpressure.
    rand_bus();
    ops = OPW'($urandom);
    txn(0, 4'b0001, ops, 10, 1'b0, u);

    // Random commands on both instances.
    for (int n = 0; n < 24; n++) begin
      int d;
      d = $urandom_range(0, 1);
      rand_bus();
      ops = OPW'($urandom);
      txn(d, NR'($urandom_range(1, 15)), ops, $urandom_range(0, 3), 1'b0, u);
    end

    // Reset while instance 1 is at element 8.
    rand_bus();
    txn(1, 4'b0001, '0, 0, 1'b0, u);
    rand_bus();
    req_op[1] = OPW'($urandom);
    req_valid[1] = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = '0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy[1], 1);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    last_owner[0] = NR - 1;
    last_owner[1] = NR - 1;
    @(negedge clk);
    rand_bus();
    ops = OPW'($urandom);
    txn(1, 4'b0100, ops, 0, 1'b0, u);
    chk("post_rst_unit", u, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
